// File: rtl/uart_if_host_sequencer.sv
// Host-side sequencer for the ISO7816-3 UART interface block. It turns a byte stream into
// register writes, drains received characters, spaces writes by a guard time and flags rx timeouts.
module uart_if_host_sequencer #(
    parameter int unsigned GUARD_WIDTH = 8,
    parameter int unsigned WAIT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [GUARD_WIDTH-1:0] guardCycles,
    input  logic [WAIT_WIDTH-1:0]  waitCycles,
    input  logic [7:0]             txByte,
    input  logic                   txValid,
    output logic                   txReady,
    output logic [7:0]             rxByte,
    output logic                   rxValid,
    output logic                   rxFrameErr,
    output logic                   rxOverrun,
    output logic                   rxTimeout,
    output logic                   busy,
    output logic [7:0]             dataIn,
    output logic                   nWeDataIn,
    input  logic [7:0]             dataOut,
    output logic                   nCsDataOut,
    input  logic [7:0]             statusOut,
    output logic                   nCsStatusOut
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WR         = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_END   = 3'd3;
    localparam logic [2:0] ST_GUARD      = 3'd4;
    localparam logic [2:0] ST_RD         = 3'd5;

    logic [2:0]             r_state;
    logic [2:0]             w_stateNext;
    logic [GUARD_WIDTH-1:0] r_guardCnt;
    logic [WAIT_WIDTH-1:0]  r_waitCnt;
    logic [WAIT_WIDTH:0]    w_waitInc;
    logic [7:0]             r_dataIn;
    logic [7:0]             r_rxByte;
    logic                   r_rxValid;
    logic                   r_rxFrameErr;
    logic                   r_rxOverrun;
    logic                   r_rxTimeout;
    logic                   r_nWeDataIn;
    logic                   r_nCsDataOut;
    logic                   r_nCsStatusOut;

    logic w_txRun;
    logic w_txPending;
    logic w_rxRun;
    logic w_rxStartBit;
    logic w_overrun;
    logic w_frameErr;
    logic w_bufferFull;
    logic w_unusedIsTx;
    logic w_rxDrain;
    logic w_idle;
    logic w_txAccept;
    logic w_waitClr;
    logic w_timeoutHit;

    assign w_txRun      = statusOut[7];
    assign w_txPending  = statusOut[6];
    assign w_rxRun      = statusOut[5];
    assign w_rxStartBit = statusOut[4];
    assign w_unusedIsTx = statusOut[3];
    assign w_overrun    = statusOut[2];
    assign w_frameErr   = statusOut[1];
    assign w_bufferFull = statusOut[0];

    // A pending rx character is only drained once the UART is not holding a tx byte.
    assign w_rxDrain  = w_bufferFull & ~w_txPending;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_txAccept = w_idle & ~w_rxDrain & txValid;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rxDrain) begin
                    w_stateNext = ST_RD;
                end else if (txValid) begin
                    w_stateNext = ST_WR;
                end
            end
            ST_WR:         w_stateNext = ST_WAIT_START;
            ST_WAIT_START: if (!w_txPending) w_stateNext = ST_WAIT_END;
            ST_WAIT_END:   if (!w_txRun) w_stateNext = ST_GUARD;
            ST_GUARD:      if (r_guardCnt == '0) w_stateNext = ST_IDLE;
            ST_RD:         w_stateNext = ST_IDLE;
            default:       w_stateNext = ST_IDLE;
        endcase
    end

    // Counter is widened by one bit so a saturated count can never alias onto waitCycles.
    assign w_waitInc    = {1'b0, r_waitCnt} + (WAIT_WIDTH + 1)'(1);
    assign w_waitClr    = ~w_idle | w_rxRun | w_rxStartBit | w_bufferFull;
    assign w_timeoutHit = ~w_waitClr && (waitCycles != '0) && (w_waitInc == {1'b0, waitCycles});

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state        <= ST_IDLE;
            r_nWeDataIn    <= 1'b1;
            r_nCsDataOut   <= 1'b1;
            r_nCsStatusOut <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_nWeDataIn    <= (w_stateNext != ST_WR);
            r_nCsDataOut   <= (w_stateNext != ST_RD);
            r_nCsStatusOut <= (w_stateNext == ST_WR) || (w_stateNext == ST_RD) ||
                              (w_stateNext == ST_GUARD);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_dataIn   <= 8'h00;
            r_guardCnt <= '0;
        end else begin
            if (w_txAccept) begin
                r_dataIn <= txByte;
            end
            if ((r_state == ST_WAIT_END) && !w_txRun) begin
                r_guardCnt <= guardCycles;
            end else if ((r_state == ST_GUARD) && (r_guardCnt != '0)) begin
                r_guardCnt <= r_guardCnt - GUARD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_rxByte     <= 8'h00;
            r_rxFrameErr <= 1'b0;
            r_rxOverrun  <= 1'b0;
            r_rxValid    <= 1'b0;
        end else begin
            r_rxValid <= (r_state == ST_RD);
            if (r_state == ST_RD) begin
                r_rxByte     <= dataOut;
                r_rxFrameErr <= w_frameErr;
                r_rxOverrun  <= w_overrun;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_waitCnt   <= '0;
            r_rxTimeout <= 1'b0;
        end else begin
            r_rxTimeout <= w_timeoutHit;
            if (w_waitClr || w_timeoutHit) begin
                r_waitCnt <= '0;
            end else if (r_waitCnt != '1) begin
                r_waitCnt <= w_waitInc[WAIT_WIDTH-1:0];
            end
        end
    end

    assign txReady      = w_idle & ~w_rxDrain;
    assign busy         = ~w_idle;
    assign dataIn       = r_dataIn;
    assign nWeDataIn    = r_nWeDataIn;
    assign nCsDataOut   = r_nCsDataOut;
    assign nCsStatusOut = r_nCsStatusOut;
    assign rxByte       = r_rxByte;
    assign rxValid      = r_rxValid;
    assign rxFrameErr   = r_rxFrameErr;
    assign rxOverrun    = r_rxOverrun;
    assign rxTimeout    = r_rxTimeout;

endmodule

// File: tb/tb_uart_if_host_sequencer.sv
// Directed bench for uart_if_host_sequencer: vector tables for rx drains and tx writes,
// plus hand-written sequences for reset, collision and the waiting-time timeout.
module tb_uart_if_host_sequencer;

    logic        clk;
    logic        nReset;
    logic [7:0]  guardCycles;
    logic [15:0] waitCycles;
    logic [7:0]  txByte;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic        rxFrameErr;
    logic        rxOverrun;
    logic        rxTimeout;
    logic        busy;
    logic [7:0]  dataIn;
    logic        nWeDataIn;
    logic [7:0]  dataOut;
    logic        nCsDataOut;
    logic [7:0]  statusOut;
    logic        nCsStatusOut;

    logic txRun, txPending, rxRun, rxStartBit, ovr, fe, bufferFull;
    assign statusOut = {txRun, txPending, rxRun, rxStartBit, 1'b0, ovr, fe, bufferFull};

    uart_if_host_sequencer #(
        .GUARD_WIDTH(8),
        .WAIT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .guardCycles (guardCycles),
        .waitCycles  (waitCycles),
        .txByte      (txByte),
        .txValid     (txValid),
        .txReady     (txReady),
        .rxByte      (rxByte),
        .rxValid     (rxValid),
        .rxFrameErr  (rxFrameErr),
        .rxOverrun   (rxOverrun),
        .rxTimeout   (rxTimeout),
        .busy        (busy),
        .dataIn      (dataIn),
        .nWeDataIn   (nWeDataIn),
        .dataOut     (dataOut),
        .nCsDataOut  (nCsDataOut),
        .statusOut   (statusOut),
        .nCsStatusOut(nCsStatusOut)
    );

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ovr;
        logic [7:0] exp_byte;
        logic       exp_fe;
        logic       exp_ovr;
    } rx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] guard;
        int         exp_gap;
    } tx_vec_t;

    rx_vec_t rx_tab[4];
    tx_vec_t tx_tab[3];

    int checks;
    int errors;
    int we_count;
    int rxv_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!nWeDataIn) we_count <= we_count + 1;
        if (rxValid) rxv_count <= rxv_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the UART side from the WR cycle onwards and counts GUARD cycles until txReady.
    task automatic tx_after_accept(output int gap);
        txPending = 1'b1;
        tick();
        check("nwe_one_cycle", nWeDataIn, 1'b1);
        tick();
        txPending = 1'b0;
        txRun     = 1'b1;
        tick();
        tick();
        check("busy_wait_end", busy, 1'b1);
        txRun = 1'b0;
        tick();
        gap = 0;
        while (!txReady && gap < 20) begin
            tick();
            gap++;
        end
    endtask

    initial begin
        int gap;
        int we_before;
        int first_to;
        int n_to;

        checks = 0; errors = 0; we_count = 0; rxv_count = 0;
        guardCycles = 8'd0; waitCycles = 16'd0; txByte = 8'h00; txValid = 1'b0;
        dataOut = 8'h00;
        {txRun, txPending, rxRun, rxStartBit, ovr, fe, bufferFull} = '0;

        rx_tab[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        rx_tab[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        rx_tab[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
        rx_tab[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tx_tab[0] = '{8'h3B, 8'd4, 5};
        tx_tab[1] = '{8'hC0, 8'd0, 1};
        tx_tab[2] = '{8'h7E, 8'd1, 2};

        nReset = 1'b1;
        #2 nReset = 1'b0;
        #10;
        check("rst_txReady", txReady, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_nWe", nWeDataIn, 1'b1);
        check("rst_nCsData", nCsDataOut, 1'b1);
        check("rst_nCsStatus", nCsStatusOut, 1'b0);
        check("rst_rxValid", rxValid, 1'b0);
        check("rst_dataIn", dataIn, 8'h00);
        check("rst_rxByte", rxByte, 8'h00);
        check("rst_rxTimeout", rxTimeout, 1'b0);
        tick();
        nReset = 1'b1;
        tick();

        // Reset asserted while the write strobe is active.
        txByte = 8'h96; txValid = 1'b1;
        tick();
        txValid = 1'b0;
        check("midwr_nWe_low", nWeDataIn, 1'b0);
        nReset = 1'b0;
        #1;
        check("midwr_nWe", nWeDataIn, 1'b1);
        check("midwr_busy", busy, 1'b0);
        check("midwr_txReady", txReady, 1'b1);
        check("midwr_dataIn", dataIn, 8'h00);
        tick();
        nReset = 1'b1;
        tick();

        // Reset asserted during a read: the character must not be delivered.
        dataOut = 8'h5A; bufferFull = 1'b1;
        tick();
        check("midrd_nCsData_low", nCsDataOut, 1'b0);
        nReset = 1'b0;
        bufferFull = 1'b0;
        #1;
        check("midrd_nCsData", nCsDataOut, 1'b1);
        check("midrd_busy", busy, 1'b0);
        tick();
        nReset = 1'b1;
        tick();
        tick();
        check("midrd_no_rxValid", rxv_count, 0);

        for (int i = 0; i < 4; i++) begin
            dataOut = rx_tab[i].data; fe = rx_tab[i].fe; ovr = rx_tab[i].ovr;
            bufferFull = 1'b1;
            #1;
            check("rx_txReady_blocked", txReady, 1'b0);
            tick();
            check("rx_nCsData_low", nCsDataOut, 1'b0);
            check("rx_nCsStatus_high", nCsStatusOut, 1'b1);
            check("rx_valid_early", rxValid, 1'b0);
            bufferFull = 1'b0;
            tick();
            dataOut = 8'h81; fe = ~rx_tab[i].fe; ovr = ~rx_tab[i].ovr;
            check("rx_valid", rxValid, 1'b1);
            check("rx_byte", rxByte, rx_tab[i].exp_byte);
            check("rx_fe", rxFrameErr, rx_tab[i].exp_fe);
            check("rx_ovr", rxOverrun, rx_tab[i].exp_ovr);
            check("rx_nCsData_high", nCsDataOut, 1'b1);
            tick();
            check("rx_valid_pulse", rxValid, 1'b0);
            check("rx_byte_hold", rxByte, rx_tab[i].exp_byte);
            fe = 1'b0; ovr = 1'b0;
        end

        for (int i = 0; i < 3; i++) begin
            we_before = we_count;
            guardCycles = tx_tab[i].guard;
            txByte = tx_tab[i].data; txValid = 1'b1;
            #1;
            check("tx_ready", txReady, 1'b1);
            tick();
            txValid = 1'b0;
            check("tx_nWe_low", nWeDataIn, 1'b0);
            check("tx_dataIn", dataIn, tx_tab[i].data);
            check("tx_nCsStatus", nCsStatusOut, 1'b1);
            check("tx_txReady_busy", txReady, 1'b0);
            tx_after_accept(gap);
            check("tx_guard_gap", gap, tx_tab[i].exp_gap);
            check("tx_single_strobe", we_count - we_before, 1);
        end

        // Collision: rx drain wins, tx byte follows exactly once.
        we_before = we_count;
        guardCycles = 8'd0;
        dataOut = 8'h55; bufferFull = 1'b1;
        txByte = 8'h3B; txValid = 1'b1;
        #1;
        check("col_txReady", txReady, 1'b0);
        tick();
        check("col_rd_first", nCsDataOut, 1'b0);
        check("col_no_wr", nWeDataIn, 1'b1);
        bufferFull = 1'b0;
        tick();
        check("col_rxValid", rxValid, 1'b1);
        check("col_rxByte", rxByte, 8'h55);
        check("col_txReady_back", txReady, 1'b1);
        tick();
        txValid = 1'b0;
        check("col_wr", nWeDataIn, 1'b0);
        check("col_dataIn", dataIn, 8'h3B);
        tx_after_accept(gap);
        check("col_gap", gap, 1);
        check("col_once", we_count - we_before, 1);
        tick();
        check("col_dataIn_hold", dataIn, 8'h3B);

        // Timeout every 10 idle cycles.
        waitCycles = 16'd10; rxRun = 1'b1;
        tick();
        rxRun = 1'b0;
        first_to = 0; n_to = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (rxTimeout) begin
                n_to++;
                if (first_to == 0) first_to = i;
                if (n_to == 2) check("to_second", i, 20);
            end
        end
        check("to_first", first_to, 10);
        check("to_count", n_to, 2);

        // rxStartBit at cycle 7 restarts the count.
        rxRun = 1'b1;
        tick();
        rxRun = 1'b0;
        first_to = 0; n_to = 0;
        for (int i = 1; i <= 30; i++) begin
            rxStartBit = (i == 7);
            tick();
            if (rxTimeout) begin
                n_to++;
                if (first_to == 0) first_to = i;
            end
        end
        rxStartBit = 1'b0;
        check("to_restart_first", first_to, 17);
        check("to_restart_count", n_to, 2);

        // Disabled timeout: counter saturates and must not wrap onto a later limit.
        waitCycles = 16'd0;
        n_to = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (rxTimeout) n_to++;
        end
        check("to_disabled", n_to, 0);
        waitCycles = 16'd10;
        n_to = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rxTimeout) n_to++;
        end
        check("to_saturated", n_to, 0);

        check("rxValid_total", rxv_count, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_if_host_sequencer.md
# uart_if_host_sequencer

Host-side sequencer driving the register interface of the ISO7816-3 half-duplex UART interface block, acting as the bus master of that interface. It turns a valid/ready byte stream into write cycles, polls the status register, drains received characters into a pulsed output with their error flags, enforces a guard time between transmitted characters and reports a character-waiting-time timeout. It sits between the reader's protocol controller (T=0/T=1 engine) and the UART interface block.

## Interface
- GUARD_WIDTH, 8: width of guardCycles.
- WAIT_WIDTH, 16: width of waitCycles and the timeout counter.
- clk  in  1  system clock; all logic on rising edge.
- nReset  in  1  asynchronous active-low reset.
- guardCycles  in  GUARD_WIDTH  idle cycles required after txRun falls before the next write.
- waitCycles  in  WAIT_WIDTH  rx waiting-time limit in clk cycles; 0 disables the timeout.
- txByte  in  8  byte to send.
- txValid  in  1  txByte valid.
- txReady  out  1  high in IDLE when a write can start; transfer when txValid&txReady.
- rxByte  out  8  last received byte.
- rxValid  out  1  one-cycle pulse, rxByte/rxFrameErr/rxOverrun valid.
- rxFrameErr  out  1  frame/parity error flag of rxByte (status bit 1).
- rxOverrun  out  1  overrun flag of rxByte (status bit 2).
- rxTimeout  out  1  one-cycle pulse on waiting-time expiry.
- busy  out  1  high in any state other than IDLE.
- dataIn  out  8  to UART interface write data.
- nWeDataIn  out  1  write strobe, active low.
- dataOut  in  8  from UART interface read data.
- nCsDataOut  out  1  read strobe, active low.
- statusOut  in  8  {txRun, txPending, rxRun, rxStartBit, isTx, overrun, frameErr, bufferFull}, bits 7..0.
- nCsStatusOut  out  1  status select, low whenever the FSM samples statusOut.

## Operation
- States: IDLE, WR, WAIT_START, WAIT_END, GUARD, RD.
- IDLE: nCsStatusOut=0. Priority 1: bufferFull=1 and txPending=0 -> RD. Priority 2: txValid=1 (txReady=1) -> latch txByte into dataIn, go WR. Otherwise stay.
- txReady = (state==IDLE) & ~(bufferFull & ~txPending); rx drain always wins over tx.
- WR: nWeDataIn=0 for exactly one cycle, nCsStatusOut=1; -> WAIT_START.
- WAIT_START: wait for txPending=0 (UART accepted the byte) -> WAIT_END.
- WAIT_END: wait for txRun=0 -> GUARD, load guard counter with guardCycles.
- GUARD: decrement each cycle; at 0 -> IDLE. guardCycles=0 -> IDLE on the next cycle.
- RD: nCsDataOut=0 for exactly one cycle, nCsStatusOut=1; capture rxByte<=dataOut, rxOverrun<=statusOut[2], rxFrameErr<=statusOut[1] on that edge; rxValid pulses the following cycle; -> IDLE.
- rxValid has no back-pressure; consumer must take it on the pulse.
- Timeout counter (WAIT_WIDTH bits, saturating): cleared to 0 in any non-IDLE state and in IDLE whenever rxRun|rxStartBit|bufferFull=1. Otherwise increments in IDLE. When counter==waitCycles and waitCycles!=0: rxTimeout pulses one cycle, counter clears. Timeout continues to repeat every waitCycles idle cycles.
- dataIn holds last written byte; unaffected by reads.

## Timing
- Reset values: state IDLE, txReady=1, busy=0, rxByte=0, rxValid=0, rxFrameErr=0, rxOverrun=0, rxTimeout=0, dataIn=0, nWeDataIn=1, nCsDataOut=1, nCsStatusOut=0, counters 0.
- All strobes are registered outputs; nWeDataIn low in the cycle after the txValid&txReady edge.
- Read latency: bufferFull seen in IDLE at edge N -> nCsDataOut low cycle N+1 -> rxValid high cycle N+2.
- Minimum byte-to-byte write spacing: WR(1)+WAIT_START(>=1)+WAIT_END(>=1)+guardCycles+1.
- Reset mid-transfer: all outputs return to reset values asynchronously; a byte in WR/WAIT states is dropped, no rxValid emitted.
- Simultaneous txValid and rx bufferFull in IDLE: RD first, tx accepted on a later IDLE cycle.
- statusOut is treated as synchronous to clk; no resynchronisation.

## Test plan
- Reset: assert nReset mid-WR -> nWeDataIn=1, busy=0, txReady=1 immediately, rxValid never pulses.
- Single tx: txByte=0x3B, guardCycles=4 -> one nWeDataIn low cycle with dataIn=0x3B; after txRun falls, txReady returns exactly 5 cycles later.
- Single rx: UART raises bufferFull with dataOut=0xA5, statusOut[2:1]=01 -> nCsDataOut low 1 cycle later, rxValid pulse with rxByte=0xA5, rxFrameErr=1, rxOverrun=0.
- Collision: txValid=1 in the same cycle bufferFull=1, txPending=0 -> RD first, then WR; byte 0x3B still sent once.
- Timeout: waitCycles=10, no rx activity in IDLE -> rxTimeout pulses at idle cycle 10 and 20; rxStartBit=1 at cycle 7 restarts count.
- Disabled timeout: waitCycles=0 for 70000 idle cycles -> rxTimeout never asserts, counter saturates without wrap.
